// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and default widths for the instruction fetch unit.
// Imported by program_counter and instr_fetch_unit.
package instr_fetch_unit_pkg;

    localparam int WORD_SIZE  = 19;
    localparam int ADDR_WIDTH = 12;

    typedef enum logic [0:0] {
        LOAD_NONE = 1'b0,
        LOAD_IR   = 1'b1
    } load_sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LOAD = 2'd2,
        EXEC = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_program_counter.sv
// Program counter register: load beats increment, increment wraps
// naturally at 2^ADDR_WIDTH.
module program_counter
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = instr_fetch_unit_pkg::ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  inc,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_value,
    output logic [ADDR_WIDTH-1:0] pc
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + ADDR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch FSM: IDLE -> REQ -> LOAD -> EXEC, feeding the IR.
// Define FETCH_TIMEOUT_EN to abandon requests that wait too long for mem_ack.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int WORD_SIZE  = instr_fetch_unit_pkg::WORD_SIZE,
    parameter int ADDR_WIDTH = instr_fetch_unit_pkg::ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  run,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [WORD_SIZE-1:0]  mem_rdata,
    output logic [WORD_SIZE-1:0]  INSTR,
    output logic                  LOAD_REG,
    output load_sel_t             LOAD_SELECT,
    input  logic                  next_fetch,
    input  logic                  branch_valid,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  busy,
    output logic                  fetch_err
);

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  pc_inc;
    logic                  pc_load;

    assign pc_inc  = (state == LOAD);
    assign pc_load = (state == EXEC) && branch_valid;

    program_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc (
        .CLK        (CLK),
        .RST        (RST),
        .inc        (pc_inc),
        .load       (pc_load),
        .load_value (branch_target),
        .pc         (pc)
    );

    assign pc_out = pc;
    assign busy   = (state != IDLE);

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] wait_cnt;
`else
    // No watchdog in this build: the error flag can never rise.
    assign fetch_err = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_addr    <= RESET_PC;
            INSTR       <= '0;
            LOAD_REG    <= 1'b0;
            LOAD_SELECT <= LOAD_NONE;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt    <= '0;
            fetch_err   <= 1'b0;
`endif
        end else begin
            LOAD_REG    <= 1'b0;
            LOAD_SELECT <= LOAD_NONE;
            unique case (state)
                IDLE: begin
                    if (run) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt  <= '0;
                        fetch_err <= 1'b0;
`endif
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        INSTR       <= mem_rdata;
                        mem_req     <= 1'b0;
                        LOAD_REG    <= 1'b1;
                        LOAD_SELECT <= LOAD_IR;
                        state       <= LOAD;
`ifdef FETCH_TIMEOUT_EN
                    end else if (wait_cnt == CNT_LAST) begin
                        mem_req   <= 1'b0;
                        fetch_err <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
`endif
                    end
                end
                LOAD: begin
                    state <= EXEC;
                end
                EXEC: begin
                    if (next_fetch) begin
                        if (run) begin
                            state    <= REQ;
                            mem_req  <= 1'b1;
                            mem_addr <= branch_valid ? branch_target : pc;
`ifdef FETCH_TIMEOUT_EN
                            wait_cnt <= '0;
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule
